// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-memory controller with configurable access latency
module data_mem_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  output logic [31:0] read_data_o32,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  logic [31:0]      ram_q [MEM_WORDS];
  logic             req;
  logic             aligned;
  logic [IDX_W-1:0] idx;
  logic             unused_addr_bits;

  assign req              = mem_read_i | mem_write_i;
  assign aligned          = (addr_i32[1:0] == 2'b00);
  assign idx              = addr_i32[2 +: IDX_W];
  assign misalign_o       = req & ~aligned;
  assign unused_addr_bits = ^addr_i32[31:2+IDX_W];

  if (LATENCY == 0) begin : g_zero_wait
    always_ff @(posedge clk_i) begin
      if (!reset_i && mem_write_i && aligned) begin
        ram_q[idx] <= write_data_i32;
      end
    end

    assign read_data_o32 = (mem_read_i && !mem_write_i && aligned) ? ram_q[idx] : '0;
    assign stall_o       = 1'b0;
    assign busy_o        = 1'b0;
  end else begin : g_fsm
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_q, wr_d;
    logic             accept;
    logic             commit;
    logic             acc_wr;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      accept  = (state_q == IDLE) && req && aligned;

      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_d   = idx;
            wdata_d = write_data_i32;
            wr_d    = mem_write_i;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase

      // With a single-cycle latency the commit edge is also the accept edge,
      // so the access must use the live inputs rather than the latches.
      commit    = (state_d == DONE) && (state_q != DONE);
      acc_idx   = accept ? idx : idx_q;
      acc_wr    = accept ? mem_write_i : wr_q;
      acc_wdata = accept ? write_data_i32 : wdata_q;
      if (commit && !acc_wr) begin
        rdata_d = ram_q[acc_idx];
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        wdata_q <= '0;
        wr_q    <= 1'b0;
        rdata_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
        rdata_q <= rdata_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_i && commit && acc_wr) begin
        ram_q[acc_idx] <= acc_wdata;
      end
    end

    assign stall_o       = accept || (state_q == BUSY);
    assign busy_o        = (state_q != IDLE);
    assign read_data_o32 = (state_q == DONE && !wr_q) ? rdata_q : '0;
  end

endmodule
